// File: rtl/fq_pkg.sv
// Shared definitions for the ball motion path: field bounds, rest position,
// FSM encoding, datapath widths and small helpers used by the motion generator.
package fq_pkg;
    localparam int POS_W = 10;
    localparam int VEL_W = 6;

    localparam logic [POS_W-1:0] X_MIN    = 10'd144;
    localparam logic [POS_W-1:0] X_MAX    = 10'd783;
    localparam logic [POS_W-1:0] Y_MIN    = 10'd35;
    localparam logic [POS_W-1:0] Y_MAX    = 10'd514;
    localparam logic [POS_W-1:0] X_CENTER = 10'd463;
    localparam logic [POS_W-1:0] Y_CENTER = 10'd275;

    typedef enum logic [1:0] {
        ST_REST   = 2'd0,
        ST_FLYING = 2'd1,
        ST_HELD   = 2'd2
    } state_e;

    // One friction step: move a velocity one unit toward zero.
    function automatic logic signed [VEL_W-1:0] vel_decay(input logic signed [VEL_W-1:0] d);
        if (d > 0)      return d - 6'sd1;
        else if (d < 0) return d + 6'sd1;
        else            return d;
    endfunction

    function automatic logic [POS_W-1:0] clamp_pos(input logic [POS_W-1:0] v,
                                                   input logic [POS_W-1:0] lo,
                                                   input logic [POS_W-1:0] hi);
        if (v < lo)      return lo;
        else if (v > hi) return hi;
        else             return v;
    endfunction
endpackage

// File: rtl/ball_motion_gen_if.sv
// Throw/catch request bus and position output bus of the ball motion generator.
//   slave  : the generator (consumes throw/catch/hold, produces position/state)
//   master : the game logic side driving requests and watching the ball
interface ball_motion_gen_if;
    import fq_pkg::*;

    logic                    throw_valid;
    logic [VEL_W-1:0]        throw_dx;
    logic [VEL_W-1:0]        throw_dy;
    logic                    throw_ready;
    logic                    catch_req;
    logic [POS_W-1:0]        hold_x;
    logic [POS_W-1:0]        hold_y;
    logic [POS_W-1:0]        x_position;
    logic [POS_W-1:0]        y_position;
    logic                    pos_valid;
    logic [1:0]              state;

    modport slave (
        input  throw_valid, throw_dx, throw_dy, catch_req, hold_x, hold_y,
        output throw_ready, x_position, y_position, pos_valid, state
    );

    modport master (
        output throw_valid, throw_dx, throw_dy, catch_req, hold_x, hold_y,
        input  throw_ready, x_position, y_position, pos_valid, state
    );
endinterface

// File: rtl/ball_motion_gen_axis_step.sv
// One axis of ball flight: p + d, mirrored back into [lo, hi] when it
// overshoots a wall (velocity sign flips). Landing exactly on a wall is
// not a bounce. Purely combinational.
//   p, d     : current position / signed velocity
//   lo, hi   : inclusive wall positions
//   p_nxt, d_nxt : position and velocity after this frame's move
module ball_axis_step
    import fq_pkg::*;
(
    input  logic [POS_W-1:0]        p,
    input  logic signed [VEL_W-1:0] d,
    input  logic [POS_W-1:0]        lo,
    input  logic [POS_W-1:0]        hi,
    output logic [POS_W-1:0]        p_nxt,
    output logic signed [VEL_W-1:0] d_nxt
);
    logic signed [POS_W:0] n, lo_s, hi_s, r;

    always_comb begin
        lo_s  = $signed({1'b0, lo});
        hi_s  = $signed({1'b0, hi});
        n     = $signed({1'b0, p}) + $signed({{(POS_W+1-VEL_W){d[VEL_W-1]}}, d});
        r     = n;
        d_nxt = d;
        // hi - (n - hi) == 2*hi - n, kept inside 11-bit range
        if (n > hi_s) begin
            r     = hi_s - (n - hi_s);
            d_nxt = -d;
        end else if (n < lo_s) begin
            r     = lo_s + (lo_s - n);
            d_nxt = -d;
        end
        p_nxt = r[POS_W-1:0];
    end
endmodule

// File: rtl/ball_motion_gen.sv
// Ball motion generator: produces the ball screen position once per frame.
// Integrates a thrown velocity with wall bounces, applies friction every
// FRICTION_FRAMES frames of flight, and tracks a holding player while caught.
//   clk, rst   : clock, synchronous active-high reset
//   frame_tick : one-cycle pulse per video frame
//   bus        : throw/catch/hold requests in, position/pos_valid/state out
module ball_motion_gen
    import fq_pkg::*;
#(
    parameter int FRICTION_FRAMES = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_tick,
    ball_motion_gen_if.slave  bus
);
    localparam logic [1:0] S_REST   = ST_REST;
    localparam logic [1:0] S_FLYING = ST_FLYING;
    localparam logic [1:0] S_HELD   = ST_HELD;
    localparam int CNT_W = $clog2(FRICTION_FRAMES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRICTION_FRAMES - 1);

    logic [1:0]              state_q;
    logic [POS_W-1:0]        x_q, y_q;
    logic signed [VEL_W-1:0] dx_q, dy_q;
    logic [CNT_W-1:0]        fcnt_q;
    logic                    pv_q;

    logic                    accept, fr_hit;
    logic signed [VEL_W-1:0] dx_in, dy_in;
    logic [POS_W-1:0]        x_mv, y_mv;
    logic signed [VEL_W-1:0] dx_mv, dy_mv, dx_f, dy_f;

    ball_axis_step u_x (.p(x_q), .d(dx_q), .lo(X_MIN), .hi(X_MAX), .p_nxt(x_mv), .d_nxt(dx_mv));
    ball_axis_step u_y (.p(y_q), .d(dy_q), .lo(Y_MIN), .hi(Y_MAX), .p_nxt(y_mv), .d_nxt(dy_mv));

    always_comb begin
        accept = bus.throw_valid && (state_q != S_FLYING);
        // -32 has no positive mirror, so it would break the bounce negation
        dx_in  = (bus.throw_dx == 6'b100000) ? -6'sd31 : $signed(bus.throw_dx);
        dy_in  = (bus.throw_dy == 6'b100000) ? -6'sd31 : $signed(bus.throw_dy);
        fr_hit = (fcnt_q == CNT_LAST);
        dx_f   = fr_hit ? vel_decay(dx_mv) : dx_mv;
        dy_f   = fr_hit ? vel_decay(dy_mv) : dy_mv;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_REST;
            x_q     <= X_CENTER;
            y_q     <= Y_CENTER;
            dx_q    <= '0;
            dy_q    <= '0;
            fcnt_q  <= '0;
            pv_q    <= 1'b0;
        end else begin
            pv_q <= frame_tick;
            // Frame update uses the state held before this edge; any
            // throw/catch below then overrides state and velocity.
            if (frame_tick) begin
                case (state_q)
                    S_HELD: begin
                        x_q <= clamp_pos(bus.hold_x, X_MIN, X_MAX);
                        y_q <= clamp_pos(bus.hold_y, Y_MIN, Y_MAX);
                    end
                    S_FLYING: begin
                        x_q    <= x_mv;
                        y_q    <= y_mv;
                        dx_q   <= dx_f;
                        dy_q   <= dy_f;
                        fcnt_q <= fr_hit ? '0 : fcnt_q + CNT_W'(1);
                        if (dx_f == 0 && dy_f == 0)
                            state_q <= S_REST;
                    end
                    default: ;
                endcase
            end
            if (accept) begin
                dx_q    <= dx_in;
                dy_q    <= dy_in;
                fcnt_q  <= '0;
                state_q <= S_FLYING;
            end else if (bus.catch_req) begin
                dx_q    <= '0;
                dy_q    <= '0;
                state_q <= S_HELD;
            end
        end
    end

    assign bus.throw_ready = (state_q != S_FLYING);
    assign bus.x_position  = x_q;
    assign bus.y_position  = y_q;
    assign bus.pos_valid   = pv_q;
    assign bus.state       = state_q;
endmodule

// File: tb/tb_ball_motion_gen.sv
module tb_ball_motion_gen;
    logic clk = 1'b0;
    logic rst;
    logic frame_tick;
    int   checks = 0;
    int   failures = 0;

    ball_motion_gen_if bus ();

    ball_motion_gen #(.FRICTION_FRAMES(8)) dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_pos(input string tag, input int ex, input int ey);
        chk({tag, ".x"}, 32'(bus.x_position), 32'(ex));
        chk({tag, ".y"}, 32'(bus.y_position), 32'(ey));
    endtask

    // One frame; returns at the negedge after the update edge.
    task automatic tick(input string tag, input int ex, input int ey);
        @(negedge clk); frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
        chk_pos(tag, ex, ey);
        chk({tag, ".pv"}, 32'(bus.pos_valid), 32'd1);
    endtask

    task automatic throw_it(input int dx, input int dy, input logic with_catch);
        @(negedge clk);
        bus.throw_valid = 1'b1;
        bus.throw_dx = 6'(dx);
        bus.throw_dy = 6'(dy);
        bus.catch_req = with_catch;
        @(negedge clk);
        bus.throw_valid = 1'b0;
        bus.catch_req = 1'b0;
        chk("throw.state", 32'(bus.state), 32'd1);
    endtask

    task automatic catch_at(input int hx, input int hy);
        bus.hold_x = 10'(hx);
        bus.hold_y = 10'(hy);
        @(negedge clk); bus.catch_req = 1'b1;
        @(negedge clk); bus.catch_req = 1'b0;
        chk("catch.state", 32'(bus.state), 32'd2);
    endtask

    initial begin
        rst = 1'b1; frame_tick = 1'b0;
        bus.throw_valid = 1'b0; bus.throw_dx = '0; bus.throw_dy = '0;
        bus.catch_req = 1'b0; bus.hold_x = '0; bus.hold_y = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_pos("reset", 463, 275);
        chk("reset.state", 32'(bus.state), 32'd0);
        chk("reset.pv", 32'(bus.pos_valid), 32'd0);
        chk("reset.ready", 32'(bus.throw_ready), 32'd1);

        // Rest frames
        for (int i = 0; i < 3; i++) begin
            tick("rest", 463, 275);
            @(negedge clk);
            chk("rest.pv_low", 32'(bus.pos_valid), 32'd0);
        end
        chk("rest.state", 32'(bus.state), 32'd0);

        // Flight with friction: 8 frames at (5,-3), then (4,-2)
        throw_it(5, -3, 1'b0);
        chk_pos("accept_nomove", 463, 275);
        chk("fly.ready", 32'(bus.throw_ready), 32'd0);
        for (int k = 1; k <= 8; k++) tick("fly", 463 + 5 * k, 275 - 3 * k);
        tick("fly_decayed", 507, 249);
        chk("fly.state", 32'(bus.state), 32'd1);

        // Right wall bounce: 780 + 10 -> 776, then moving left
        catch_at(780, 275);
        tick("held_r", 780, 275);
        throw_it(10, 0, 1'b1);
        tick("bounce_r", 776, 275);
        tick("bounce_r2", 766, 275);

        // Left wall: exact landing on 144 is not a bounce; next frame bounces
        catch_at(150, 275);
        tick("held_l", 150, 275);
        throw_it(-6, 0, 1'b0);
        tick("land_min", 144, 275);
        tick("bounce_l", 150, 275);

        // Held clamping at both extremes
        catch_at(900, 10);
        tick("clamp_hi", 783, 35);
        bus.hold_x = 10'd0; bus.hold_y = 10'd1023;
        tick("clamp_lo", 144, 514);

        // -32 throw clamps to -31
        bus.hold_x = 10'd400; bus.hold_y = 10'd275;
        tick("held_400", 400, 275);
        throw_it(-32, 0, 1'b1);
        tick("clamp_m32", 369, 275);

        // Zero throw returns to REST on the next frame
        catch_at(369, 275);
        throw_it(0, 0, 1'b0);
        tick("zero_throw", 369, 275);
        chk("zero.state", 32'(bus.state), 32'd0);

        // Decay to rest from (1,0); throw during flight ignored
        throw_it(1, 0, 1'b0);
        for (int k = 1; k <= 7; k++) begin
            tick("decay", 369 + k, 275);
            chk("decay.state", 32'(bus.state), 32'd1);
            if (k == 3) begin
                @(negedge clk);
                bus.throw_valid = 1'b1; bus.throw_dx = 6'd9; bus.throw_dy = 6'd9;
                chk("busy.ready", 32'(bus.throw_ready), 32'd0);
                @(negedge clk);
                bus.throw_valid = 1'b0;
            end
        end
        tick("decay_end", 377, 275);
        chk("decay_end.state", 32'(bus.state), 32'd0);

        // Throw accept coinciding with frame_tick: frame handled as HELD
        catch_at(200, 100);
        @(negedge clk);
        bus.throw_valid = 1'b1; bus.throw_dx = 6'd2; bus.throw_dy = 6'd2; frame_tick = 1'b1;
        @(negedge clk);
        bus.throw_valid = 1'b0; frame_tick = 1'b0;
        chk_pos("tick_accept", 200, 100);
        chk("tick_accept.pv", 32'(bus.pos_valid), 32'd1);
        chk("tick_accept.state", 32'(bus.state), 32'd1);
        tick("after_tick_accept", 202, 102);

        // Reset mid-flight
        catch_at(600, 300);
        tick("held_600", 600, 300);
        throw_it(7, 7, 1'b0);
        tick("fly7", 607, 307);
        @(negedge clk); rst = 1'b1; frame_tick = 1'b1;
        @(negedge clk);
        chk_pos("mid_rst", 463, 275);
        chk("mid_rst.state", 32'(bus.state), 32'd0);
        chk("mid_rst.pv", 32'(bus.pos_valid), 32'd0);
        rst = 1'b0; frame_tick = 1'b0;
        tick("post_rst", 463, 275);
        chk("post_rst.state", 32'(bus.state), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
